inst_fetch: RTL and testbench

//  Instruction fetch stage: owns the PC and fetches 32-bit words over a req/ack instruction bus.

---
 rtl/inst_fetch.sv | 146 ++++++++++++++
 tb/tb_inst_fetch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack bus and presents
// registered {valid, pc, inst} to decode, with one-word stall buffering and redirect flush.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;

    logic [31:0] redirect_tgt;
    logic [31:0] pc_inc;

    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign pc_inc       = pc_q + 32'd4;

    // DISCARD keeps requesting the stale address so the bus transaction can complete.
    assign ibus_req  = !rst && (state_q != HOLD);
    assign ibus_addr = pc_q;

    assign if_valid = valid_q;
    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;

    // NOTE: every next-value gets its hold default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        target_d    = target_q;
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;
        valid_d     = valid_q;
        if_pc_d     = if_pc_q;
        if_inst_d   = if_inst_q;

        case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    valid_d   = 1'b0;
                    if_inst_d = NOP_INST;
                    if (ibus_ack) begin
                        pc_d = redirect_tgt;
                    end else begin
                        // pc_q must stay put while the stale request is still open.
                        target_d = redirect_tgt;
                        state_d  = DISCARD;
                    end
                end else if (ibus_ack) begin
                    pc_d = pc_inc;
                    if (stall) begin
                        hold_inst_d = ibus_rdata;
                        hold_pc_d   = pc_q;
                        state_d     = HOLD;
                    end else begin
                        valid_d   = 1'b1;
                        if_pc_d   = pc_q;
                        if_inst_d = ibus_rdata;
                    end
                end else if (!stall) begin
                    valid_d   = 1'b0;
                    if_inst_d = NOP_INST;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    valid_d   = 1'b0;
                    if_inst_d = NOP_INST;
                    pc_d      = redirect_tgt;
                    state_d   = FETCH;
                end else if (!stall) begin
                    valid_d   = 1'b1;
                    if_pc_d   = hold_pc_q;
                    if_inst_d = hold_inst_q;
                    state_d   = FETCH;
                end
            end

            DISCARD: begin
                valid_d   = 1'b0;
                if_inst_d = NOP_INST;
                if (redirect_valid) begin
                    target_d = redirect_tgt;
                end
                if (ibus_ack) begin
                    pc_d    = redirect_valid ? redirect_tgt : target_q;
                    state_d = FETCH;
                end
            end

            default: state_d = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            target_q    <= '0;
            hold_inst_q <= '0;
            hold_pc_q   <= '0;
            valid_q     <= 1'b0;
            if_pc_q     <= '0;
            if_inst_q   <= NOP_INST;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            target_q    <= target_d;
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
            valid_q     <= valid_d;
            if_pc_q     <= if_pc_d;
            if_inst_q   <= if_inst_d;
        end
    end

    // An ack without an outstanding request is a bus protocol violation.
    ack_needs_req: assert property (@(posedge clk) disable iff (rst) !(ibus_ack && !ibus_req));

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: the script pushes each instruction it expects the decoder
// to accept; a separate monitor pops and compares whenever if_valid && !stall.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack = 1'b0;
    logic [31:0] ibus_rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];

    inst_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ibus_req       (ibus_req),
        .ibus_addr      (ibus_addr),
        .ibus_ack       (ibus_ack),
        .ibus_rdata     (ibus_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        exp_q.push_back('{pc: pc, inst: inst});
    endtask

    // Drive inputs for one cycle, then return at the following falling edge.
    task automatic cyc(input logic s, input logic r, input logic [31:0] rp,
                       input logic a, input logic [31:0] d);
        stall          = s;
        redirect_valid = r;
        redirect_pc    = rp;
        ibus_ack       = a;
        ibus_rdata     = d;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #1;
        check("rst_req_low", {31'b0, ibus_req}, 32'd0);
        idle();
        check("rst_if_valid", {31'b0, if_valid}, 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_inst", if_inst, NOP);
        rst = 1'b0;
        #1;
        check("rst_req", {31'b0, ibus_req}, 32'd1);
        check("rst_addr", ibus_addr, RESET_PC);
    endtask

    // Scoreboard monitor: samples late in the cycle, after inputs have settled.
    always @(negedge clk) begin
        #3;
        if (!rst && if_valid && !stall) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_issue: got pc=%h inst=%h expected none", if_pc, if_inst);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("issue_pc", if_pc, e.pc);
                check("issue_inst", if_inst, e.inst);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Zero-wait bus: one instruction per cycle, if_pc lags the address by one.
        push(32'h8000_0000, 32'h00A0_0093);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h00A0_0093);
        check("t1_addr1", ibus_addr, 32'h8000_0004);
        check("t1_valid", {31'b0, if_valid}, 32'd1);
        check("t1_pc0", if_pc, 32'h8000_0000);
        push(32'h8000_0004, 32'h00B0_0113);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h00B0_0113);
        check("t1_addr2", ibus_addr, 32'h8000_0008);
        check("t1_pc1", if_pc, 32'h8000_0004);
        push(32'h8000_0008, 32'h00C0_0193);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h00C0_0193);
        check("t1_addr3", ibus_addr, 32'h8000_000C);

        // Three wait states per fetch: address stable, bubbles show NOP.
        for (int f = 0; f < 2; f++) begin
            logic [31:0] a;
            a = 32'h8000_000C + 32'(4 * f);
            for (int w = 0; w < 4; w++) begin
                check("t2_req", {31'b0, ibus_req}, 32'd1);
                check("t2_addr", ibus_addr, a);
                if (w == 3) begin
                    push(a, 32'h0100_0000 + a);
                    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0100_0000 + a);
                    check("t2_valid_pulse", {31'b0, if_valid}, 32'd1);
                    check("t2_pc", if_pc, a);
                end else begin
                    idle();
                    check("t2_bubble", {31'b0, if_valid}, 32'd0);
                    check("t2_nop", if_inst, NOP);
                end
            end
        end
        check("t2_next_addr", ibus_addr, 32'h8000_0014);

        // Stall across an ack: word buffered, bus idle, outputs frozen.
        do_reset();
        push(32'h8000_0000, 32'h1111_0013);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_0013);
        check("t3_addr", ibus_addr, 32'h8000_0004);
        push(32'h8000_0004, 32'h2222_0013);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h2222_0013);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_req", {31'b0, ibus_req}, 32'd0);
            check("t3_frozen_pc", if_pc, 32'h8000_0000);
            check("t3_frozen_valid", {31'b0, if_valid}, 32'd1);
            cyc((i < 4), 1'b0, 32'h0, 1'b0, 32'h0);
        end
        check("t3_release_pc", if_pc, 32'h8000_0004);
        check("t3_release_inst", if_inst, 32'h2222_0013);
        check("t3_resume_req", {31'b0, ibus_req}, 32'd1);
        check("t3_resume_addr", ibus_addr, 32'h8000_0008);
        push(32'h8000_0008, 32'h3333_0013);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h3333_0013);

        // Redirect while a fetch is pending: stale word dropped, latest target wins.
        do_reset();
        push(32'h8000_0000, 32'h4444_0013);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h4444_0013);
        push(32'h8000_0004, 32'h5555_0013);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h5555_0013);
        check("t4_addr_pre", ibus_addr, 32'h8000_0008);
        cyc(1'b0, 1'b1, 32'h8000_1002, 1'b0, 32'h0);
        check("t4_discard_addr", ibus_addr, 32'h8000_0008);
        check("t4_discard_req", {31'b0, ibus_req}, 32'd1);
        check("t4_flush_valid", {31'b0, if_valid}, 32'd0);
        check("t4_flush_nop", if_inst, NOP);
        idle();
        check("t4_discard_addr2", ibus_addr, 32'h8000_0008);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        check("t4_target_addr", ibus_addr, 32'h8000_1000);
        check("t4_stale_dropped", {31'b0, if_valid}, 32'd0);
        push(32'h8000_1000, 32'h6666_0013);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h6666_0013);
        check("t4_target_pc", if_pc, 32'h8000_1000);
        cyc(1'b0, 1'b1, 32'h8000_3000, 1'b0, 32'h0);
        check("t4b_addr_held", ibus_addr, 32'h8000_1004);
        cyc(1'b0, 1'b1, 32'h8000_4000, 1'b0, 32'h0);
        check("t4b_addr_held2", ibus_addr, 32'h8000_1004);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0001);
        check("t4b_latest_target", ibus_addr, 32'h8000_4000);
        push(32'h8000_4000, 32'h7777_0013);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h7777_0013);

        // Redirect together with stall, from FETCH then from HOLD.
        do_reset();
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0AA0_0013);
        check("t5_shown", {31'b0, if_valid}, 32'd1);
        cyc(1'b1, 1'b1, 32'h8000_5000, 1'b0, 32'h0);
        check("t5_fetch_flush", {31'b0, if_valid}, 32'd0);
        check("t5_fetch_nop", if_inst, NOP);
        check("t5_old_addr", ibus_addr, 32'h8000_0004);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'hBAD0_0002);
        check("t5_target1", ibus_addr, 32'h8000_5000);
        push(32'h8000_5000, 32'h8888_0013);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h8888_0013);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0BB0_0013);
        check("t5_shown2", if_pc, 32'h8000_5004);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'hBAD0_0003);
        check("t5_hold_req", {31'b0, ibus_req}, 32'd0);
        cyc(1'b1, 1'b1, 32'h8000_7000, 1'b0, 32'h0);
        check("t5_hold_flush", {31'b0, if_valid}, 32'd0);
        check("t5_hold_req_back", {31'b0, ibus_req}, 32'd1);
        check("t5_target2", ibus_addr, 32'h8000_7000);
        push(32'h8000_7000, 32'h9999_0013);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h9999_0013);
        check("t5_resume_pc", if_pc, 32'h8000_7000);

        // PC wraparound, then reset during a wait-state fetch.
        do_reset();
        push(32'h8000_0000, 32'hAAAA_0013);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hAAAA_0013);
        cyc(1'b0, 1'b1, 32'hFFFF_FFFD, 1'b1, 32'hBAD0_0004);
        check("t6_redirect_ack_addr", ibus_addr, 32'hFFFF_FFFC);
        check("t6_redirect_ack_valid", {31'b0, if_valid}, 32'd0);
        push(32'hFFFF_FFFC, 32'hBBBB_0013);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hBBBB_0013);
        check("t6_wrap_addr", ibus_addr, 32'h0000_0000);
        check("t6_wrap_pc", if_pc, 32'hFFFF_FFFC);
        idle();
        idle();
        check("t6_wait_addr", ibus_addr, 32'h0000_0000);
        rst = 1'b1;
        #1;
        check("t6_rst_req", {31'b0, ibus_req}, 32'd0);
        idle();
        rst = 1'b0;
        check("t6_rst_valid", {31'b0, if_valid}, 32'd0);
        #1;
        check("t6_restart_req", {31'b0, ibus_req}, 32'd1);
        check("t6_restart_addr", ibus_addr, RESET_PC);
        push(32'h8000_0000, 32'hCCCC_0013);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hCCCC_0013);
        idle();
        idle();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
